rptr_ctrl: RTL



---
 rtl/rptr_ctrl_if.sv | 27 ++
 rtl/rptr_ctrl.sv | 75 +++++++
 2 files changed

// File: rtl/rptr_ctrl_if.sv
// Pop request bundle for the FIFO read-side pointer controller.
// master drives r_en/r_num/clr_err; slave returns r_done/underflow.
interface rptr_ctrl_if #(
  parameter int PTR_WIDTH = 3
);
  logic                 r_en;
  logic [PTR_WIDTH:0]   r_num;
  logic                 clr_err;
  logic                 r_done;
  logic                 underflow;

  modport master (
    output r_en,
    output r_num,
    output clr_err,
    input  r_done,
    input  underflow
  );

  modport slave (
    input  r_en,
    input  r_num,
    input  clr_err,
    output r_done,
    output underflow
  );
endinterface

// File: rtl/rptr_ctrl.sv
// Read-side pointer controller: binary/Gray read pointers, fill level,
// empty/almost-empty flags, multi-entry pops and sticky underflow.
// Ports: rclk, rrst (sync, active-high), pop (slave: r_en, r_num,
// clr_err, r_done, underflow), g_wptr_sync, b_rptr, g_rptr, rlevel,
// empty, almost_empty.
module rptr_ctrl #(
  parameter int PTR_WIDTH = 3,
  parameter int AE_LEVEL  = 1
) (
  input  logic               rclk,
  input  logic               rrst,
  rptr_ctrl_if.slave         pop,
  input  logic [PTR_WIDTH:0] g_wptr_sync,
  output logic [PTR_WIDTH:0] b_rptr,
  output logic [PTR_WIDTH:0] g_rptr,
  output logic [PTR_WIDTH:0] rlevel,
  output logic               empty,
  output logic               almost_empty
);

  localparam int PW = PTR_WIDTH;
  localparam logic [PW:0] AE_L = (PW+1)'(AE_LEVEL);

  logic [PW:0] wbin;
  logic [PW:0] b_next;
  logic [PW:0] g_next;
  logic [PW:0] lvl_next;
  logic        accept;
  logic        reject;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= PW; i++) begin
      wbin[i] = ^(g_wptr_sync >> i);
    end
  end

  // Judged against registered rlevel: the true level can only be
  // higher, since the write pointer never moves backwards.
  always_comb begin
    accept   = pop.r_en && (pop.r_num != '0)
               && (pop.r_num <= rlevel);
    reject   = pop.r_en && (pop.r_num > rlevel);
    b_next   = b_rptr + (accept ? pop.r_num : '0);
    g_next   = (b_next >> 1) ^ b_next;
    lvl_next = wbin - b_next;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      b_rptr        <= '0;
      g_rptr        <= '0;
      rlevel        <= '0;
      empty         <= 1'b1;
      almost_empty  <= 1'b1;
      pop.r_done    <= 1'b0;
      pop.underflow <= 1'b0;
    end else begin
      b_rptr       <= b_next;
      g_rptr       <= g_next;
      rlevel       <= lvl_next;
      empty        <= (lvl_next == '0);
      almost_empty <= (lvl_next <= AE_L);
      pop.r_done   <= accept;
      // Set has priority over clear.
      if (reject) begin
        pop.underflow <= 1'b1;
      end else if (pop.clr_err) begin
        pop.underflow <= 1'b0;
      end
    end
  end

endmodule
